lsu_mem_port: RTL and testbench

Load/store request front-end that sits directly upstream of the byte-interleaved data memory. It accepts one access per cycle over a valid/ready request channel and drives the memory's address, width, sign-extend, data and write-enable inputs. It captures the memory's one-cycle-late read data into a 2-entry response FIFO so the core gets an in-order valid/ready response stream with backpressure. Accesses that would run past the end of memory are rejected with an error response and never touch the memory.

---
 rtl/mem_cfg_pkg.sv | 29 ++
 rtl/lsu_rsp_fifo.sv | 58 +++++
 rtl/lsu_mem_port.sv | 109 ++++++++++
 tb/tb_lsu_mem_port.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_cfg_pkg.sv
// Shared memory-access types: access width encoding, LSU response payload
// and the width-to-byte-count helper used by the range check.
package mem_cfg_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE     = 2'd0,
        MEM_HALFWORD = 2'd1,
        MEM_WORD     = 2'd2
    } mem_width_t;

    typedef struct packed {
        logic [31:0] data;
        logic        write;
        logic        error;
    } lsu_rsp_t;

    // Returns 0 for any encoding outside the enum so callers can flag it.
    function automatic logic [2:0] mem_width_bytes(input mem_width_t width);
        logic [2:0] w_bytes;
        case (width)
            MEM_BYTE:     w_bytes = 3'd1;
            MEM_HALFWORD: w_bytes = 3'd2;
            MEM_WORD:     w_bytes = 3'd4;
            default:      w_bytes = 3'd0;
        endcase
        return w_bytes;
    endfunction

endpackage

// File: rtl/lsu_rsp_fifo.sv
// Two-entry in-order response FIFO. The head reads as zero whenever the
// FIFO is empty so the response outputs are quiet while nothing is valid.
module lsu_rsp_fifo
    import mem_cfg_pkg::*;
#(
    parameter type T = lsu_rsp_t
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  T           push_data_i,
    input  logic       pop_i,
    output T           head_o,
    output logic [1:0] count_o
);

    T           r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;

    // Storage, pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= push_data_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop_i) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry, forced to zero while empty.
    always_comb begin
        head_o = '0;
        if (r_count != 2'd0) begin
            head_o = r_mem[r_rd_ptr];
        end else begin
            head_o = '0;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store front-end for the byte-interleaved data memory: range check,
// one-cycle tag stage matching the memory read latency, and response FIFO.
module lsu_mem_port
    import mem_cfg_pkg::*;
#(
    parameter int  MEMORY_DEPTH_BYTES = 1024,
    localparam int AddrWidth          = $clog2(MEMORY_DEPTH_BYTES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  mem_width_t           req_width_i,
    input  logic                 req_sign_extend_i,
    input  logic                 req_write_i,
    input  logic [31:0]          req_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_write_o,
    output logic                 rsp_error_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output mem_width_t           mem_width_o,
    output logic                 mem_sign_extend_o,
    output logic [31:0]          mem_data_o,
    output logic                 mem_write_enable_o,
    input  logic [31:0]          mem_data_i
);

    localparam logic [AddrWidth:0] DepthLimit = (AddrWidth + 1)'(MEMORY_DEPTH_BYTES);

    logic [2:0]         w_size;
    logic [AddrWidth:0] w_end;
    logic               w_error;
    logic               w_issue;
    logic               w_pop;
    logic [1:0]         w_count;
    logic [2:0]         w_occupancy;
    lsu_rsp_t           w_push_data;
    lsu_rsp_t           w_head;

    logic               r_inflight;
    logic               r_tag_write;
    logic               r_tag_error;

    // One extra bit on the end address so a WORD at depth-1 cannot wrap to 0.
    assign w_size  = mem_width_bytes(req_width_i);
    assign w_end   = {1'b0, req_addr_i} + (AddrWidth + 1)'(w_size);
    assign w_error = (w_size == 3'd0) || (w_end > DepthLimit);

    assign rsp_valid_o = (w_count != 2'd0);
    assign w_pop       = rsp_valid_o && rsp_ready_i;

    // Combinational path from rsp_ready_i keeps full throughput while draining.
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign req_ready_o = !rst_i && (w_occupancy < 3'd2);
    assign w_issue     = req_valid_i && req_ready_o;

    assign mem_addr_o         = req_addr_i;
    assign mem_width_o        = req_width_i;
    assign mem_sign_extend_o  = req_sign_extend_i;
    assign mem_data_o         = req_data_i;
    assign mem_write_enable_o = w_issue && req_write_i && !w_error;

    // Stage-1 tag register, aligned with the memory's one-cycle read latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight  <= 1'b0;
            r_tag_write <= 1'b0;
            r_tag_error <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_write <= req_write_i;
                r_tag_error <= w_error;
            end
        end
    end

    // Response entry: read data only for a good load.
    always_comb begin
        w_push_data       = '0;
        w_push_data.write = r_tag_write;
        w_push_data.error = r_tag_error;
        if (r_tag_write || r_tag_error) begin
            w_push_data.data = 32'd0;
        end else begin
            w_push_data.data = mem_data_i;
        end
    end

    lsu_rsp_fifo #(
        .T (lsu_rsp_t)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (r_inflight),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    assign rsp_data_o  = w_head.data;
    assign rsp_write_o = w_head.write;
    assign rsp_error_o = w_head.error;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural byte memory attached.
module tb_lsu_mem_port;
    import mem_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [9:0]  req_addr_i;
    mem_width_t  req_width_i;
    logic        req_sign_extend_i;
    logic        req_write_i;
    logic [31:0] req_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_write_o;
    logic        rsp_error_o;
    logic [9:0]  mem_addr_o;
    mem_width_t  mem_width_o;
    logic        mem_sign_extend_o;
    logic [31:0] mem_data_o;
    logic        mem_write_enable_o;
    logic [31:0] mem_data_i;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_q [0:1023];

    always #5 clk = ~clk;

    lsu_mem_port dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_addr_i         (req_addr_i),
        .req_width_i        (req_width_i),
        .req_sign_extend_i  (req_sign_extend_i),
        .req_write_i        (req_write_i),
        .req_data_i         (req_data_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_ready_i        (rsp_ready_i),
        .rsp_data_o         (rsp_data_o),
        .rsp_write_o        (rsp_write_o),
        .rsp_error_o        (rsp_error_o),
        .mem_addr_o         (mem_addr_o),
        .mem_width_o        (mem_width_o),
        .mem_sign_extend_o  (mem_sign_extend_o),
        .mem_data_o         (mem_data_o),
        .mem_write_enable_o (mem_write_enable_o),
        .mem_data_i         (mem_data_i)
    );

    function automatic int nbytes(mem_width_t w);
        case (w)
            MEM_BYTE:     return 1;
            MEM_HALFWORD: return 2;
            MEM_WORD:     return 4;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [31:0] mem_read(logic [9:0] a, mem_width_t w, logic sx);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = nbytes(w);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_q[(int'(a) + i) % 1024];
        if (sx && n == 1) v[31:8] = {24{v[7]}};
        if (sx && n == 2) v[31:16] = {16{v[15]}};
        return v;
    endfunction

    // Byte memory with internal address wrap and one-cycle read latency.
    always @(posedge clk) begin
        if (mem_write_enable_o) begin
            for (int i = 0; i < 4; i++) begin
                if (i < nbytes(mem_width_o)) mem_q[(int'(mem_addr_o) + i) % 1024] <= mem_data_o[8*i +: 8];
            end
        end
        mem_data_i <= mem_read(mem_addr_o, mem_width_o, mem_sign_extend_o);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [9:0] a, mem_width_t w, logic sx, logic wr, logic [31:0] d);
        req_valid_i       = v;
        req_addr_i        = a;
        req_width_i       = w;
        req_sign_extend_i = sx;
        req_write_i       = wr;
        req_data_i        = d;
    endtask

    task automatic idle();
        drive(1'b0, 10'd0, MEM_BYTE, 1'b0, 1'b0, 32'd0);
    endtask

    // Single request with rsp_ready_i high; response checked exactly 2 cycles later.
    task automatic xact(string tag, logic [9:0] a, mem_width_t w, logic sx, logic wr,
                        logic [31:0] d, logic [31:0] ed, logic ee);
        drive(1'b1, a, w, sx, wr, d);
        #1;
        check({tag, "_rdy"}, 32'(req_ready_o), 32'd1);
        check({tag, "_we"}, 32'(mem_write_enable_o), 32'(wr & ~ee));
        next();
        idle();
        #1;
        check({tag, "_early"}, 32'(rsp_valid_o), 32'd0);
        next();
        check({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        check({tag, "_data"}, rsp_data_o, ed);
        check({tag, "_write"}, 32'(rsp_write_o), 32'(wr));
        check({tag, "_error"}, 32'(rsp_error_o), 32'(ee));
        next();
    endtask

    initial begin
        rst_i       = 1'b1;
        rsp_ready_i = 1'b1;
        idle();
        #2;
        check("rst_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_data", rsp_data_o, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        next();

        // Aligned store then load, back to back.
        drive(1'b1, 10'h010, MEM_WORD, 1'b0, 1'b1, 32'hDEADBEEF);
        #1;
        check("st_we", 32'(mem_write_enable_o), 32'd1);
        next();
        drive(1'b1, 10'h010, MEM_WORD, 1'b0, 1'b0, 32'd0);
        #1;
        check("st_n1_valid", 32'(rsp_valid_o), 32'd0);
        check("ld_we", 32'(mem_write_enable_o), 32'd0);
        next();
        idle();
        #1;
        check("st_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("st_rsp_write", 32'(rsp_write_o), 32'd1);
        check("st_rsp_data", rsp_data_o, 32'd0);
        next();
        check("ld_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("ld_rsp_data", rsp_data_o, 32'hDEADBEEF);
        check("ld_rsp_error", 32'(rsp_error_o), 32'd0);
        next();
        check("ab_empty", 32'(rsp_valid_o), 32'd0);

        // Misaligned halfword across a word boundary, sign extended.
        xact("sb13a", 10'h013, MEM_BYTE, 1'b0, 1'b1, 32'h00000080, 32'd0, 1'b0);
        xact("sb14a", 10'h014, MEM_BYTE, 1'b0, 1'b1, 32'h00000001, 32'd0, 1'b0);
        xact("lh13a", 10'h013, MEM_HALFWORD, 1'b1, 1'b0, 32'd0, 32'h00000180, 1'b0);
        xact("sb13b", 10'h013, MEM_BYTE, 1'b0, 1'b1, 32'h00000001, 32'd0, 1'b0);
        xact("sb14b", 10'h014, MEM_BYTE, 1'b0, 1'b1, 32'h00000080, 32'd0, 1'b0);
        xact("lh13b", 10'h013, MEM_HALFWORD, 1'b1, 1'b0, 32'd0, 32'hFFFF8001, 1'b0);

        // Range boundaries and illegal width.
        xact("sw000", 10'h000, MEM_WORD, 1'b0, 1'b1, 32'h11223344, 32'd0, 1'b0);
        xact("sw3fe", 10'h3FE, MEM_WORD, 1'b0, 1'b1, 32'hCAFEF00D, 32'd0, 1'b1);
        xact("lw000", 10'h000, MEM_WORD, 1'b0, 1'b0, 32'd0, 32'h11223344, 1'b0);
        xact("sw3fc", 10'h3FC, MEM_WORD, 1'b0, 1'b1, 32'hA5A55A5A, 32'd0, 1'b0);
        xact("lw3fc", 10'h3FC, MEM_WORD, 1'b0, 1'b0, 32'd0, 32'hA5A55A5A, 1'b0);
        xact("lb3ff", 10'h3FF, MEM_BYTE, 1'b1, 1'b0, 32'd0, 32'hFFFFFFA5, 1'b0);
        xact("lh3ff", 10'h3FF, MEM_HALFWORD, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        xact("lill", 10'h000, mem_width_t'(2'd3), 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // Eight back-to-back loads after preloading the words.
        for (int i = 0; i < 8; i++) begin
            xact("pre", 10'h100 + 10'(4 * i), MEM_WORD, 1'b0, 1'b1, 32'hC0DE0000 + 32'(i), 32'd0, 1'b0);
        end
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(1'b1, 10'h100 + 10'(4 * c), MEM_WORD, 1'b0, 1'b0, 32'd0);
            else idle();
            #1;
            if (c < 8) check("b2b_rdy", 32'(req_ready_o), 32'd1);
            if (c >= 2) begin
                check("b2b_valid", 32'(rsp_valid_o), 32'd1);
                check("b2b_data", rsp_data_o, 32'hC0DE0000 + 32'(c - 2));
            end else begin
                check("b2b_pre_valid", 32'(rsp_valid_o), 32'd0);
            end
            next();
        end
        check("b2b_end", 32'(rsp_valid_o), 32'd0);

        // Backpressure: only two accepted while the consumer stalls.
        rsp_ready_i = 1'b0;
        drive(1'b1, 10'h100, MEM_WORD, 1'b0, 1'b0, 32'd0);
        #1;
        check("bp_rdy0", 32'(req_ready_o), 32'd1);
        next();
        drive(1'b1, 10'h104, MEM_WORD, 1'b0, 1'b0, 32'd0);
        #1;
        check("bp_rdy1", 32'(req_ready_o), 32'd1);
        next();
        drive(1'b1, 10'h108, MEM_WORD, 1'b0, 1'b0, 32'd0);
        #1;
        check("bp_rdy2", 32'(req_ready_o), 32'd0);
        check("bp_head2", rsp_data_o, 32'hC0DE0000);
        next();
        check("bp_rdy3", 32'(req_ready_o), 32'd0);
        check("bp_head3", rsp_data_o, 32'hC0DE0000);
        next();
        rsp_ready_i = 1'b1;
        #1;
        check("bp_rdy4", 32'(req_ready_o), 32'd1);
        check("bp_head4", rsp_data_o, 32'hC0DE0000);
        next();
        drive(1'b1, 10'h10C, MEM_WORD, 1'b0, 1'b0, 32'd0);
        #1;
        check("bp_rdy5", 32'(req_ready_o), 32'd1);
        check("bp_head5", rsp_data_o, 32'hC0DE0001);
        next();
        idle();
        #1;
        check("bp_head6", rsp_data_o, 32'hC0DE0002);
        next();
        check("bp_head7", rsp_data_o, 32'hC0DE0003);
        next();
        check("bp_empty", 32'(rsp_valid_o), 32'd0);

        // Asynchronous reset with one queued and one inflight response.
        rsp_ready_i = 1'b0;
        drive(1'b1, 10'h100, MEM_WORD, 1'b0, 1'b0, 32'd0);
        next();
        drive(1'b1, 10'h104, MEM_WORD, 1'b0, 1'b0, 32'd0);
        next();
        idle();
        #1;
        check("ar_pre_valid", 32'(rsp_valid_o), 32'd1);
        rst_i = 1'b1;
        drive(1'b1, 10'h000, MEM_WORD, 1'b0, 1'b1, 32'hBAD0BAD0);
        #1;
        check("ar_valid", 32'(rsp_valid_o), 32'd0);
        check("ar_data", rsp_data_o, 32'd0);
        check("ar_write", 32'(rsp_write_o), 32'd0);
        check("ar_error", 32'(rsp_error_o), 32'd0);
        check("ar_ready", 32'(req_ready_o), 32'd0);
        check("ar_we", 32'(mem_write_enable_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle();
        rsp_ready_i = 1'b1;
        #1;
        check("ar_rel_valid", 32'(rsp_valid_o), 32'd0);
        next();
        check("ar_stale1", 32'(rsp_valid_o), 32'd0);
        next();
        check("ar_stale2", 32'(rsp_valid_o), 32'd0);
        xact("ar_lw000", 10'h000, MEM_WORD, 1'b0, 1'b0, 32'd0, 32'h11223344, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
